// File: rtl/fir_avg_out.sv
// ---------------------------------------------------------------------------
// fir_avg_out
//   Output stage of the 4-tap unsigned averaging FIR. Takes the w+2-bit tap
//   sum, divides it by 4, drops the warm-up sums that arrive before the tap
//   window is full, and buffers the averages in a small FIFO. The consumer
//   side uses a valid/ready handshake.
//
//   Handshake: a head entry transfers on any rising edge where
//   avg_vld && avg_rdy. avg_vld never depends on avg_rdy. avg and avg_vld
//   hold steady while avg_vld && !avg_rdy. avg_rdy is ignored while the FIFO
//   is empty.
//
//   Build option: FIR_AVG_ROUND_EN
//     defined   -> avg = (s + 2) >> 2 (round half up)
//     undefined -> avg = s >> 2       (truncation, no adder)
//
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous active-high reset (flushes FIFO, restarts warm-up)
//     s          in   [w+1:0] unsigned 4-tap sum
//     s_vld      in   s carries a new sum
//     avg        out  [w-1:0] FIFO head, 0 when empty
//     avg_vld    out  FIFO non-empty
//     avg_rdy    in   consumer accepts head
//     count      out  [$clog2(DEPTH):0] FIFO occupancy
//     fill_done  out  warm-up complete
//     ovf        out  sticky: a post-warm-up sum was dropped
// ---------------------------------------------------------------------------
module fir_avg_out #(
    parameter int w      = 4,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [w+1:0]             s,
    input  logic                     s_vld,
    output logic [w-1:0]             avg,
    output logic                     avg_vld,
    input  logic                     avg_rdy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fill_done,
    output logic                     ovf
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WUW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WUW-1:0] WLAST = (WARMUP > 0) ? WUW'(WARMUP - 1) : '0;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    // -----------------------------------------------------------------------
    // Divide by 4
    // -----------------------------------------------------------------------
    logic [w-1:0] avg_calc;

`ifdef FIR_AVG_ROUND_EN
    // One extra bit catches out-of-range sums (above 4*(2^w-1)) whose +2
    // would wrap; those saturate to the largest average instead.
    logic [w+2:0] rnd_sum;
    assign rnd_sum  = {1'b0, s} + (w+3)'(2);
    assign avg_calc = rnd_sum[w+2] ? '1 : rnd_sum[w+1:2];
`else
    logic unused_s_lsb;
    assign unused_s_lsb = ^s[1:0];
    assign avg_calc     = s[w+1:2];
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WUW-1:0] wcnt_q, wcnt_d;
    logic           fill_done_q, fill_done_d;
    logic           ovf_q, ovf_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [w-1:0]   mem_q [DEPTH];

    logic full, empty, push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = !empty && avg_rdy;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign push  = s_vld && fill_done_q && (!full || pop);

    always_comb begin
        wcnt_d      = wcnt_q;
        fill_done_d = fill_done_q;
        ovf_d       = ovf_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;

        // Warm-up: the sum that completes the window is itself discarded,
        // so the flag rises on the same edge that consumes that sum.
        if (!fill_done_q) begin
            if (WARMUP == 0) begin
                fill_done_d = 1'b1;
            end else if (s_vld) begin
                wcnt_d = wcnt_q + WUW'(1);
                if (wcnt_q == WLAST) begin
                    fill_done_d = 1'b1;
                end
            end
        end

        if (s_vld && fill_done_q && full && !pop) begin
            ovf_d = 1'b1;
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q      <= '0;
            fill_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            fill_done_q <= fill_done_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: it is only visible through avg while non-empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= avg_calc;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign avg_vld   = !empty;
    assign avg       = empty ? '0 : mem_q[rptr_q];
    assign count     = count_q;
    assign fill_done = fill_done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_avg_out.sv
module tb_fir_avg_out;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W+1:0] s;
  logic         s_vld;
  logic [W-1:0] avg;
  logic         avg_vld;
  logic         avg_rdy;
  logic [2:0]   count;
  logic         fill_done;
  logic         ovf;

  fir_avg_out #(.w(W), .DEPTH(4), .WARMUP(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .s         (s),
    .s_vld     (s_vld),
    .avg       (avg),
    .avg_vld   (avg_vld),
    .avg_rdy   (avg_rdy),
    .count     (count),
    .fill_done (fill_done),
    .ovf       (ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: averages expected to come out of the FIFO, in order
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are stable 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset   = 1'b1;
    s_vld   = 1'b0;
    s       = '0;
    avg_rdy = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [W+1:0] v);
    s_vld = 1'b1;
    s     = v;
    tick();
    s_vld = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_avg"},  32'(avg), 32'h0);
    check({tag, "_vld"},  32'(avg_vld), 32'h0);
    check({tag, "_cnt"},  32'(count), 32'h0);
    check({tag, "_fill"}, 32'(fill_done), 32'h0);
    check({tag, "_ovf"},  32'(ovf), 32'h0);
  endtask

  // drain the FIFO against the scoreboard, one pop per cycle
  task automatic drain(input string tag);
    logic [W-1:0] e;
    avg_rdy = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_vld"}, 32'(avg_vld), 32'h1);
      check({tag, "_avg"}, 32'(avg), 32'(e));
      tick();
    end
    check({tag, "_empty_cnt"}, 32'(count), 32'h0);
    check({tag, "_empty_vld"}, 32'(avg_vld), 32'h0);
  endtask

  // rounding vectors: {s, expected avg}
  logic [W+1:0] rv_s   [4] = '{6'h06, 6'h05, 6'h3A, 6'h3E};
`ifdef FIR_AVG_ROUND_EN
  logic [W-1:0] rv_exp [4] = '{4'h2, 4'h1, 4'hF, 4'hF};
`else
  logic [W-1:0] rv_exp [4] = '{4'h1, 4'h1, 4'hE, 4'hF};
`endif

  logic [W+1:0] fill_s   [5] = '{6'h04, 6'h08, 6'h0C, 6'h10, 6'h14};
  logic [W-1:0] fill_exp [4] = '{4'h1, 4'h2, 4'h3, 4'h4};

  initial begin
    reset   = 1'b1;
    s       = '0;
    s_vld   = 1'b0;
    avg_rdy = 1'b0;

    // 1. reset and idle
    tick();
    check_idle("rst_hold");
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("idle");
    end

    // 2. warm-up: three discarded, fourth pushed
    avg_rdy = 1'b1;
    send(6'h3C);
    check("wu1_fill", 32'(fill_done), 32'h0);
    check("wu1_cnt", 32'(count), 32'h0);
    send(6'h3C);
    check("wu2_fill", 32'(fill_done), 32'h0);
    send(6'h3C);
    check("wu3_fill", 32'(fill_done), 32'h1);
    check("wu3_vld", 32'(avg_vld), 32'h0);
    send(6'h3C);
    check("wu4_vld", 32'(avg_vld), 32'h1);
    check("wu4_avg", 32'(avg), 32'hF);
    check("wu4_cnt", 32'(count), 32'h1);
    tick();
    check("wu_pop_vld", 32'(avg_vld), 32'h0);
    check("wu_pop_avg", 32'(avg), 32'h0);
    check("wu_pop_cnt", 32'(count), 32'h0);

    // 3. rounding
    for (int i = 0; i < 4; i++) begin
      send(rv_s[i]);
      check($sformatf("rnd%0d_vld", i), 32'(avg_vld), 32'h1);
      check($sformatf("rnd%0d_avg", i), 32'(avg), 32'(rv_exp[i]));
      tick();
      check($sformatf("rnd%0d_cnt", i), 32'(count), 32'h0);
    end

    // 4. overflow
    avg_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(fill_s[i]);
      exp_q.push_back(fill_exp[i]);
    end
    check("ovf_full_cnt", 32'(count), 32'h4);
    check("ovf_pre", 32'(ovf), 32'h0);
    send(fill_s[4]);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_cnt", 32'(count), 32'h4);
    tick();
    check("ovf_hold_avg", 32'(avg), 32'h1);
    check("ovf_sticky", 32'(ovf), 32'h1);
    drain("ovf_drain");
    check("ovf_after_drain", 32'(ovf), 32'h1);

    // 5. full with simultaneous push and pop
    do_reset(1);
    for (int i = 0; i < 3; i++) send(6'h00);
    check("pp_fill", 32'(fill_done), 32'h1);
    check("pp_warm_cnt", 32'(count), 32'h0);
    for (int i = 0; i < 4; i++) begin
      send(fill_s[i]);
      exp_q.push_back(fill_exp[i]);
    end
    check("pp_full_cnt", 32'(count), 32'h4);
    avg_rdy = 1'b1;
    send(6'h20);
    void'(exp_q.pop_front());
    exp_q.push_back(4'h8);
    avg_rdy = 1'b0;
    check("pp_cnt", 32'(count), 32'h4);
    check("pp_ovf", 32'(ovf), 32'h0);
    drain("pp_drain");

    // 6. reset mid-operation
    avg_rdy = 1'b0;
    for (int i = 0; i < 5; i++) send(fill_s[i]);
    avg_rdy = 1'b1;
    tick();
    avg_rdy = 1'b0;
    check("mr_pre_cnt", 32'(count), 32'h3);
    check("mr_pre_ovf", 32'(ovf), 32'h1);
    check("mr_pre_avg", 32'(avg), 32'h2);
    do_reset(1);
    check_idle("mr_post");
    for (int i = 0; i < 3; i++) begin
      send(6'h10);
      check($sformatf("mr_wu%0d_cnt", i), 32'(count), 32'h0);
    end
    check("mr_wu_fill", 32'(fill_done), 32'h1);
    send(6'h18);
    check("mr_first_cnt", 32'(count), 32'h1);
    check("mr_first_avg", 32'(avg), 32'h6);
    check("mr_first_vld", 32'(avg_vld), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // guard against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
